mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter READ_LATENCY, default 1, meaning ROM/RAM read latency in clock cycles; legal range 1-3.
REQ-002 clock  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents an access.
REQ-005 req_ready  output  1  controller accepts an access.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  8  access address.
REQ-008 req_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  requester consumes the response.
REQ-011 rsp_rdata  output  8  read data; 0 for writes and errors.
REQ-012 rsp_err  output  1  access was illegal.
REQ-013 address  output  8  address driven to ROM, RAM and the read-data mux.
REQ-014 data_in  output  8  write data to RAM.
REQ-015 write_en  output  1  RAM write strobe, one cycle.
REQ-016 data_out  input  8  read data returned by the read-data mux.
REQ-017 port_out_00, port_out_01  output  8 each  output port registers.

Function
REQ-018 Address map: ROM 0x00-0x7F (read-only); RAM 0x80-0xDF (read/write); port_out_00 at 0xE0 and port_out_01 at 0xE1 (write-only); input ports at 0xF0 and 0xF1 (read-only); all other addresses unmapped.
REQ-019 FSM states: IDLE, ACCESS, WAIT, RESP; only one access is outstanding at a time.
REQ-020 IDLE: req_ready=1; on req_valid&req_ready, the FSM latches addr, wdata and write, then goes to ACCESS; all other states hold req_ready=0.
REQ-021 address and data_in drive the latched values from ACCESS through RESP; they hold their last value in IDLE.
REQ-022 ACCESS with a legal RAM write: write_en=1 for exactly this cycle, then RESP.
REQ-023 ACCESS with a legal port write: the selected port_out register loads wdata at the end of this cycle, then RESP.
REQ-024 ACCESS with a legal read: go to WAIT and count READ_LATENCY cycles, counting ACCESS as the first; on the final counted cycle, rsp_rdata captures data_out and the FSM goes to RESP.
REQ-025 Errors: a write to ROM or to an input port, a read of 0xE0 or 0xE1, or any unmapped address goes ACCESS->RESP with rsp_err=1 and rsp_rdata=0; there is no write_en and no port update.
REQ-026 RESP: rsp_valid=1 and rsp_rdata/rsp_err stay stable until rsp_ready; on rsp_ready the FSM returns to IDLE and rsp_valid falls on the next cycle.
REQ-027 A req_valid asserted outside IDLE is not accepted; the requester must hold it.
REQ-028 Minimum occupancy: 3 cycles for a write or error (IDLE, ACCESS, RESP); 3+READ_LATENCY-1 cycles for a read.

Reset
REQ-029 Reset forces IDLE and clears, immediately: req_ready→1 and rsp_valid, rsp_err, rsp_rdata, address, data_in, write_en, port_out_00 and port_out_01→0.
REQ-030 Reset during an access aborts it: no response is issued and a write_en in progress drops asynchronously.

Configuration
REQ-031 Macro MEM_BUS_CTRL_COUNT_EN: when defined, adds outputs rd_count[15:0] and wr_count[15:0], incremented on each successful read or write response handshake, saturating at 0xFFFF and reset to 0; error responses are not counted.
REQ-032 When MEM_BUS_CTRL_COUNT_EN is undefined, the counters and ports are absent and behaviour is otherwise identical.

Structure
REQ-033 Package mem_map_pkg holds the range constants (ROM_LO/HI, RAM_LO/HI, PORT_OUT_00/01, PORT_IN_00/01), the FSM state enum and an access-class enum (ROM, RAM, PORT_OUT, PORT_IN, UNMAPPED).
REQ-034 One combinational sub-module, mem_addr_decode, maps an address to its access class; the read-data mux keeps using the same constants.

Verification
REQ-035 Write 0x5A to 0x90, then read 0x90 with a RAM model at READ_LATENCY=1 -> write_en pulses once with address=0x90 and data_in=0x5A; the read returns rsp_rdata=0x5A and rsp_err=0.
REQ-036 Write 0x3C to 0xE1 -> port_out_01=0x3C after ACCESS, port_out_00 unchanged, rsp_err=0.
REQ-037 Write to 0x10, write to 0xF0, and read 0xE5 -> each returns rsp_err=1 and rsp_rdata=0; no write_en; ports unchanged.
REQ-038 Read 0xF0 with data_out=0xA7 and READ_LATENCY=3 -> rsp_valid rises exactly 4 cycles after acceptance with rsp_rdata=0xA7.
REQ-039 Hold rsp_ready=0 for 5 cycles with req_valid high -> rsp_valid and rsp_rdata stay stable, req_ready=0, and no second access is accepted.
REQ-040 Assert reset in the ACCESS cycle of a RAM write -> write_en=0 immediately, the FSM returns to IDLE, no rsp_valid, and ports read 0.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Address map constants, FSM states and access classes shared by the memory bus controller,
// its address decoder and any read-data mux built around it.
package mem_map_pkg;

    localparam logic [7:0] ROM_LO      = 8'h00;
    localparam logic [7:0] ROM_HI      = 8'h7F;
    localparam logic [7:0] RAM_LO      = 8'h80;
    localparam logic [7:0] RAM_HI      = 8'hDF;
    localparam logic [7:0] PORT_OUT_00 = 8'hE0;
    localparam logic [7:0] PORT_OUT_01 = 8'hE1;
    localparam logic [7:0] PORT_IN_00  = 8'hF0;
    localparam logic [7:0] PORT_IN_01  = 8'hF1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        ROM,
        RAM,
        PORT_OUT,
        PORT_IN,
        UNMAPPED
    } acc_class_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and mem_bus_ctrl (slave).
interface mem_bus_ctrl_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_addr_decode.sv
// Combinational address-to-access-class decoder for the memory bus address map.
module mem_addr_decode
    import mem_map_pkg::*;
(
    input  logic [7:0] addr,
    output acc_class_t acc_class
);

    always_comb begin
        acc_class = UNMAPPED;
        // ROM starts at address zero, so only the upper bound needs comparing
        if (addr <= ROM_HI) begin
            acc_class = ROM;
        end else if (addr >= RAM_LO && addr <= RAM_HI) begin
            acc_class = RAM;
        end else if (addr == PORT_OUT_00 || addr == PORT_OUT_01) begin
            acc_class = PORT_OUT;
        end else if (addr == PORT_IN_00 || addr == PORT_IN_01) begin
            acc_class = PORT_IN;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding memory bus controller for ROM/RAM/port space with configurable read latency.
// Define MEM_BUS_CTRL_COUNT_EN to add saturating rd_count/wr_count handshake counters.
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
)
(
    input  logic          clock,
    input  logic          reset,
    mem_bus_ctrl_if.slave bus,
    output logic [7:0]    address,
    output logic [7:0]    data_in,
    output logic          write_en,
    input  logic [7:0]    data_out,
    output logic [7:0]    port_out_00,
    output logic [7:0]    port_out_01
`ifdef MEM_BUS_CTRL_COUNT_EN
    ,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
`endif
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    state_t     state, state_n;
    acc_class_t acc_class;

    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       write_q;
    logic [7:0] rdata_q;
    logic       err_q;
    logic [1:0] lat_cnt;

    logic       accept;
    logic       legal;
    logic       capture;
    logic       port_we;

    mem_addr_decode u_decode (
        .addr      (addr_q),
        .acc_class (acc_class)
    );

    always_comb begin
        if (write_q) begin
            legal = (acc_class == RAM) || (acc_class == PORT_OUT);
        end else begin
            legal = (acc_class == ROM) || (acc_class == RAM) || (acc_class == PORT_IN);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (write_q || !legal) begin
                    state_n = RESP;
                end else if (READ_LATENCY <= 1) begin
                    capture = 1'b1;
                    state_n = RESP;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so a reset drops them without waiting for a clock
    assign accept        = (state == IDLE) && bus.req_valid;
    assign write_en      = (state == ACCESS) && write_q && (acc_class == RAM);
    assign port_we       = (state == ACCESS) && write_q && (acc_class == PORT_OUT);
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign address       = addr_q;
    assign data_in       = wdata_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            lat_cnt     <= '0;
            port_out_00 <= '0;
            port_out_01 <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
            end
            if (state == ACCESS) begin
                err_q   <= !legal;
                rdata_q <= '0;
                lat_cnt <= 2'd1;
            end
            if (state == WAIT) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            // Placed after the ACCESS clear so a single-cycle read keeps the captured data
            if (capture) begin
                rdata_q <= data_out;
            end
            if (port_we) begin
                if (addr_q == PORT_OUT_00) begin
                    port_out_00 <= wdata_q;
                end else begin
                    port_out_01 <= wdata_q;
                end
            end
        end
    end

`ifdef MEM_BUS_CTRL_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if ((state == RESP) && bus.rsp_ready && !err_q) begin
            if (write_q) begin
                if (wr_count != '1) begin
                    wr_count <= wr_count + 16'd1;
                end
            end else begin
                if (rd_count != '1) begin
                    rd_count <= rd_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: vector table on a READ_LATENCY=1 instance plus
// hand-written backpressure, reset-abort and READ_LATENCY=3 sequences.
module tb_mem_bus_ctrl;
    import mem_map_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_bus_ctrl_if bus1 ();
    mem_bus_ctrl_if bus3 ();

    logic [1:0] rv = 2'b00;
    logic [1:0] rr = 2'b00;
    logic       t_write = 1'b0;
    logic [7:0] t_addr  = 8'h00;
    logic [7:0] t_wdata = 8'h00;

    assign bus1.req_valid = rv[0];
    assign bus1.rsp_ready = rr[0];
    assign bus1.req_write = t_write;
    assign bus1.req_addr  = t_addr;
    assign bus1.req_wdata = t_wdata;
    assign bus3.req_valid = rv[1];
    assign bus3.rsp_ready = rr[1];
    assign bus3.req_write = t_write;
    assign bus3.req_addr  = t_addr;
    assign bus3.req_wdata = t_wdata;

    logic [7:0] address1, data_in1, data_out1, p0_1, p1_1;
    logic       write_en1;
    logic [7:0] address3, data_in3, data_out3, p0_3, p1_3;
    logic       write_en3;
`ifdef MEM_BUS_CTRL_COUNT_EN
    logic [15:0] rc1, wc1, rc3, wc3;
`endif

    mem_bus_ctrl #(.READ_LATENCY(1)) u_dut1 (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus1),
        .address     (address1),
        .data_in     (data_in1),
        .write_en    (write_en1),
        .data_out    (data_out1),
        .port_out_00 (p0_1),
        .port_out_01 (p1_1)
`ifdef MEM_BUS_CTRL_COUNT_EN
        ,
        .rd_count    (rc1),
        .wr_count    (wc1)
`endif
    );

    mem_bus_ctrl #(.READ_LATENCY(3)) u_dut3 (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus3),
        .address     (address3),
        .data_in     (data_in3),
        .write_en    (write_en3),
        .data_out    (data_out3),
        .port_out_00 (p0_3),
        .port_out_01 (p1_3)
`ifdef MEM_BUS_CTRL_COUNT_EN
        ,
        .rd_count    (rc3),
        .wr_count    (wc3)
`endif
    );

    // Memory model: ROM content is addr^0x5C, RAM starts zeroed, input ports are fixed values
    logic [7:0]  ram [256] = '{default: 8'h00};
    int unsigned we_total = 0;
    logic [7:0]  we_addr  = 8'h00;
    logic [7:0]  we_data  = 8'h00;

    always @(posedge clock) begin
        if (write_en1) begin
            ram[address1] <= data_in1;
            we_total      <= we_total + 1;
            we_addr       <= address1;
            we_data       <= data_in1;
        end
    end

    function automatic logic [7:0] rd_mux(input logic [7:0] a);
        if (a <= ROM_HI)                  return a ^ 8'h5C;
        else if (a >= RAM_LO && a <= RAM_HI) return ram[a];
        else if (a == PORT_IN_00)         return 8'hA7;
        else if (a == PORT_IN_01)         return 8'h1B;
        else                              return 8'h00;
    endfunction

    always_comb data_out1 = rd_mux(address1);
    always_comb data_out3 = rd_mux(address3);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // One complete transaction on instance sel (0: latency 1, 1: latency 3)
    task automatic do_access(input int sel, input logic wr, input logic [7:0] a,
                             input logic [7:0] wd, output logic [7:0] rd,
                             output logic er, output int cyc);
        int guard;
        rd  = 8'h00;
        er  = 1'b0;
        cyc = 0;
        @(negedge clock);
        t_write = wr;
        t_addr  = a;
        t_wdata = wd;
        rv[sel] = 1'b1;
        rr[sel] = 1'b0;
        guard = 0;
        while (!(sel == 0 ? bus1.req_ready : bus3.req_ready) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!(sel == 0 ? bus1.req_ready : bus3.req_ready)) begin
            timeout("req_ready");
            rv[sel] = 1'b0;
            return;
        end
        @(negedge clock);
        rv[sel] = 1'b0;
        cyc = 1;
        while (!(sel == 0 ? bus1.rsp_valid : bus3.rsp_valid) && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        if (!(sel == 0 ? bus1.rsp_valid : bus3.rsp_valid)) begin
            timeout("rsp_valid");
            return;
        end
        rd = (sel == 0) ? bus1.rsp_rdata : bus3.rsp_rdata;
        er = (sel == 0) ? bus1.rsp_err : bus3.rsp_err;
        rr[sel] = 1'b1;
        @(negedge clock);
        rr[sel] = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic       exp_we;
        logic [7:0] exp_p0;
        logic [7:0] exp_p1;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [7:0]  rd;
        logic        er;
        int          cyc;
        int unsigned we0;
        int          guard;

        vecs[0]  = '{1'b1, 8'h90, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 8'h90, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 8'hE1, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3C};
        vecs[3]  = '{1'b1, 8'h10, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h3C};
        vecs[4]  = '{1'b1, 8'hF0, 8'h77, 8'h00, 1'b1, 1'b0, 8'h00, 8'h3C};
        vecs[5]  = '{1'b0, 8'hE5, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h3C};
        vecs[6]  = '{1'b0, 8'hE0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h3C};
        vecs[7]  = '{1'b0, 8'h10, 8'h00, 8'h4C, 1'b0, 1'b0, 8'h00, 8'h3C};
        vecs[8]  = '{1'b0, 8'hF1, 8'h00, 8'h1B, 1'b0, 1'b0, 8'h00, 8'h3C};
        vecs[9]  = '{1'b1, 8'hE0, 8'hC3, 8'h00, 1'b0, 1'b0, 8'hC3, 8'h3C};
        vecs[10] = '{1'b1, 8'hDF, 8'h81, 8'h00, 1'b0, 1'b1, 8'hC3, 8'h3C};
        vecs[11] = '{1'b0, 8'hDF, 8'h00, 8'h81, 1'b0, 1'b0, 8'hC3, 8'h3C};
        vecs[12] = '{1'b0, 8'h7F, 8'h00, 8'h23, 1'b0, 1'b0, 8'hC3, 8'h3C};
        vecs[13] = '{1'b1, 8'h80, 8'hE7, 8'h00, 1'b0, 1'b1, 8'hC3, 8'h3C};
        vecs[14] = '{1'b0, 8'h80, 8'h00, 8'hE7, 1'b0, 1'b0, 8'hC3, 8'h3C};
        vecs[15] = '{1'b0, 8'hE2, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC3, 8'h3C};
        vecs[16] = '{1'b1, 8'hFF, 8'h12, 8'h00, 1'b1, 1'b0, 8'hC3, 8'h3C};
        vecs[17] = '{1'b0, 8'hF0, 8'h00, 8'hA7, 1'b0, 1'b0, 8'hC3, 8'h3C};

        #12;
        chk("rst_req_ready", 16'(bus1.req_ready), 16'h1);
        chk("rst_rsp_valid", 16'(bus1.rsp_valid), 16'h0);
        chk("rst_rsp_err",   16'(bus1.rsp_err),   16'h0);
        chk("rst_rsp_rdata", 16'(bus1.rsp_rdata), 16'h0);
        chk("rst_address",   16'(address1),       16'h0);
        chk("rst_data_in",   16'(data_in1),       16'h0);
        chk("rst_write_en",  16'(write_en1),      16'h0);
        chk("rst_port0",     16'(p0_1),           16'h0);
        chk("rst_port1",     16'(p1_1),           16'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            we0 = we_total;
            do_access(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, cyc);
            chk($sformatf("v%0d_rdata", i), 16'(rd), 16'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_err", i), 16'(er), 16'(vecs[i].exp_err));
            chk($sformatf("v%0d_cycles", i), 16'(cyc), 16'd2);
            chk($sformatf("v%0d_we_pulses", i), 16'(we_total - we0), 16'(vecs[i].exp_we));
            chk($sformatf("v%0d_port0", i), 16'(p0_1), 16'(vecs[i].exp_p0));
            chk($sformatf("v%0d_port1", i), 16'(p1_1), 16'(vecs[i].exp_p1));
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_we_addr", i), 16'(we_addr), 16'(vecs[i].addr));
                chk($sformatf("v%0d_we_data", i), 16'(we_data), 16'(vecs[i].wdata));
            end
        end

        // Backpressure: response held 5 cycles while a second request waits
        we0 = we_total;
        @(negedge clock);
        t_write = 1'b0;
        t_addr  = 8'h90;
        rv[0]   = 1'b1;
        rr[0]   = 1'b0;
        chk("bp_idle_ready", 16'(bus1.req_ready), 16'h1);
        @(negedge clock);
        t_write = 1'b1;
        t_addr  = 8'h91;
        t_wdata = 8'h11;
        guard = 0;
        while (!bus1.rsp_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!bus1.rsp_valid) timeout("bp_rsp_valid");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_rsp_valid", k), 16'(bus1.rsp_valid), 16'h1);
            chk($sformatf("bp%0d_rdata", k), 16'(bus1.rsp_rdata), 16'h5A);
            chk($sformatf("bp%0d_req_ready", k), 16'(bus1.req_ready), 16'h0);
            @(negedge clock);
        end
        rv[0] = 1'b0;
        rr[0] = 1'b1;
        @(negedge clock);
        rr[0] = 1'b0;
        chk("bp_rsp_valid_fall", 16'(bus1.rsp_valid), 16'h0);
        chk("bp_no_write", 16'(we_total - we0), 16'h0);
        do_access(0, 1'b0, 8'h91, 8'h00, rd, er, cyc);
        chk("bp_0x91_unwritten", 16'(rd), 16'h00);

        // Reset asserted in the ACCESS cycle of a RAM write
        we0 = we_total;
        @(negedge clock);
        t_write = 1'b1;
        t_addr  = 8'h95;
        t_wdata = 8'h66;
        rv[0]   = 1'b1;
        @(posedge clock);
        #1;
        rv[0] = 1'b0;
        chk("ra_we_in_access", 16'(write_en1), 16'h1);
        #1 reset = 1'b1;
        #1;
        chk("ra_we_drop", 16'(write_en1), 16'h0);
        chk("ra_req_ready", 16'(bus1.req_ready), 16'h1);
        chk("ra_rsp_valid", 16'(bus1.rsp_valid), 16'h0);
        chk("ra_address", 16'(address1), 16'h0);
        chk("ra_port0", 16'(p0_1), 16'h0);
        chk("ra_port1", 16'(p1_1), 16'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("ra%0d_no_rsp", k), 16'(bus1.rsp_valid), 16'h0);
        end
        chk("ra_no_write", 16'(we_total - we0), 16'h0);
        do_access(0, 1'b0, 8'h95, 8'h00, rd, er, cyc);
        chk("ra_0x95_unwritten", 16'(rd), 16'h00);

        // READ_LATENCY=3 instance: reads take ACCESS + 2 WAIT cycles
        do_access(1, 1'b0, 8'hF0, 8'h00, rd, er, cyc);
        chk("l3_f0_cycles", 16'(cyc), 16'd4);
        chk("l3_f0_rdata", 16'(rd), 16'hA7);
        chk("l3_f0_err", 16'(er), 16'h0);
        do_access(1, 1'b0, 8'h10, 8'h00, rd, er, cyc);
        chk("l3_rom_cycles", 16'(cyc), 16'd4);
        chk("l3_rom_rdata", 16'(rd), 16'h4C);
        do_access(1, 1'b1, 8'h05, 8'h99, rd, er, cyc);
        chk("l3_romwr_cycles", 16'(cyc), 16'd2);
        chk("l3_romwr_err", 16'(er), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
